// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, functs, ALU controls
// and the decoded control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef struct packed {
        logic      reg_write;
        logic      reg_dst;
        logic      alu_src;
        logic      mem_to_reg;
        logic      mem_write;
        logic      branch;
        logic      jump;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two async read ports, one sync write port, async active-low clear.
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    // $0 is hardwired on the read side so a stray write can never leak out
    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_single_cycle_top.sv
// Single-cycle MIPS subset core: PC, instruction ROM, decoder, regfile, ALU and data RAM.
// Every instruction completes in one clock; the store bus is exported for observation.
module mips_single_cycle_top
    import mips_pkg::*;
#(
    parameter string IMEM_FILE  = "memfile.dat",
    parameter int    IMEM_WORDS = 64,
    parameter int    DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite
);

    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0] pc, pc_next, pc_plus4, instr, imm_ext;
    logic [31:0] rd1, rd2, src_b, alu_result, read_data, result;
    logic [4:0]  write_reg;
    logic        zero;
    ctrl_t       ctrl;

    assign instr    = imem[pc[IA+1:2]];
    assign imm_ext  = sign_ext(instr[15:0]);
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        ctrl          = '0;
        ctrl.alu_ctrl = ALU_ADD;
        unique case (instr[31:26])
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                unique case (instr[5:0])
                    FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:  ctrl.alu_ctrl = ALU_AND;
                    FN_OR:   ctrl.alu_ctrl = ALU_OR;
                    FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
                    default: ctrl.reg_write = 1'b0;  // unknown funct retires as a NOP
                endcase
            end
            OP_LW:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.mem_to_reg = 1'b1; end
            OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
            OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; end
            OP_BEQ:  begin ctrl.branch = 1'b1; ctrl.alu_ctrl = ALU_SUB; end
            OP_J:    ctrl.jump = 1'b1;
            default: ;
        endcase
    end

    mips_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (ctrl.reg_write),
        .ra1   (instr[25:21]),
        .ra2   (instr[20:16]),
        .wa    (write_reg),
        .wd    (result),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    assign src_b = ctrl.alu_src ? imm_ext : rd2;

    always_comb begin
        alu_result = '0;
        case (ctrl.alu_ctrl)
            ALU_AND: alu_result = rd1 & src_b;
            ALU_OR:  alu_result = rd1 | src_b;
            ALU_ADD: alu_result = rd1 + src_b;
            ALU_SUB: alu_result = rd1 - src_b;
            ALU_SLT: alu_result = {31'b0, $signed(rd1) < $signed(src_b)};
            default: alu_result = '0;
        endcase
    end

    assign zero      = (alu_result == 32'd0);
    assign write_reg = ctrl.reg_dst ? instr[15:11] : instr[20:16];
    assign read_data = dmem[alu_result[DA+1:2]];
    assign result    = ctrl.mem_to_reg ? read_data : alu_result;

    assign writedata = rd2;
    assign dataadr   = alu_result;
    assign memwrite  = ctrl.mem_write & reset;

    // RAM deliberately has no reset; contents survive a core reset
    always_ff @(posedge clk) begin
        if (memwrite) dmem[alu_result[DA+1:2]] <= rd2;
    end

    always_comb begin
        pc_next = pc_plus4;
        if (ctrl.jump)
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (ctrl.branch && zero)
            pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else        pc <= pc_next;
    end

    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

endmodule

// File: tb/tb_mips_single_cycle_top.sv
// Directed bench for the single-cycle MIPS core: small programs poked into the ROM,
// per-cycle PC and store-bus expectations computed by hand.
module tb_mips_single_cycle_top;

    logic        clk;
    logic        reset;
    logic [31:0] writedata;
    logic [31:0] dataadr;
    logic        memwrite;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prog [16];

    mips_single_cycle_top #(
        .IMEM_FILE  (""),
        .IMEM_WORDS (64),
        .DMEM_WORDS (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .writedata (writedata),
        .dataadr   (dataadr),
        .memwrite  (memwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load(input int n);
        for (int i = 0; i < 64; i++) dut.imem[i] = (i < n) ? prog[i] : 32'h0;
    endtask

    task automatic start(input int n);
        reset = 1'b0;
        load(n);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic set_prog1();
        prog[0] = 32'h20020064; prog[1] = 32'hac02001e;
        prog[2] = 32'h8c03001e; prog[3] = 32'hac030014;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_prog1();
        load(4);
        @(negedge clk); @(negedge clk); #1;
        n_tests++;
        if (dut.pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want %h", dut.pc, 32'd0); end
        n_tests++;
        if (memwrite !== 1'b0) begin n_fail++; $display("FAIL reset_memwrite got %b want 0", memwrite); end
        n_tests++;
        if (dataadr !== 32'd100) begin n_fail++; $display("FAIL reset_dataadr got %h want %h", dataadr, 32'd100); end
    endtask

    task automatic test_store_prog();
        logic [31:0] e_pc  [4] = '{0, 4, 8, 12};
        bit          e_mw  [4] = '{0, 1, 0, 1};
        logic [31:0] e_adr [4] = '{100, 30, 30, 20};
        logic [31:0] e_wd  [4] = '{0, 100, 0, 100};
        set_prog1();
        start(4);
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (dut.pc !== e_pc[c] || memwrite !== e_mw[c] || dataadr !== e_adr[c] || writedata !== e_wd[c]) begin
                n_fail++;
                $display("FAIL store_prog c%0d got pc=%h mw=%b adr=%h wd=%h want pc=%h mw=%b adr=%h wd=%h",
                         c, dut.pc, memwrite, dataadr, writedata, e_pc[c], e_mw[c], e_adr[c], e_wd[c]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e_pc  [4] = '{0, 4, 8, 12};
        bit          e_mw  [4] = '{0, 1, 0, 1};
        logic [31:0] e_adr [4] = '{100, 30, 30, 20};
        logic [31:0] e_wd  [4] = '{0, 100, 0, 100};
        set_prog1();
        start(4);
        @(negedge clk); #1;            // now at pc 4, the first sw
        reset = 1'b0;
        #1;
        n_tests++;
        if (dut.pc !== 32'd0) begin n_fail++; $display("FAIL mid_reset_async_pc got %h want 0", dut.pc); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_tests++;
            if (dut.pc !== 32'd0 || memwrite !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_hold c%0d got pc=%h mw=%b want pc=0 mw=0", c, dut.pc, memwrite);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (dut.pc !== e_pc[c] || memwrite !== e_mw[c] || dataadr !== e_adr[c] || writedata !== e_wd[c]) begin
                n_fail++;
                $display("FAIL mid_reset_rerun c%0d got pc=%h mw=%b adr=%h wd=%h want pc=%h mw=%b adr=%h wd=%h",
                         c, dut.pc, memwrite, dataadr, writedata, e_pc[c], e_mw[c], e_adr[c], e_wd[c]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_alu_slt();
        bit          e_mw  [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic [31:0] e_adr [9] = '{32'hFFFFFFFB, 3, 1, 0, 32'hFFFFFFFE, 8, 3, 32'hFFFFFFFB, 0};
        logic [31:0] e_wd  [9] = '{0, 0, 3, 1, 3, 32'hFFFFFFFB, 3, 3, 32'hFFFFFFFB};
        prog[0] = 32'h2001FFFB; prog[1] = 32'h20020003; prog[2] = 32'h0022182A;
        prog[3] = 32'hAC030000; prog[4] = 32'h00222020; prog[5] = 32'h00412822;
        prog[6] = 32'h00223024; prog[7] = 32'h00223825; prog[8] = 32'h0041402A;
        start(9);
        for (int c = 0; c < 9; c++) begin
            n_tests++;
            if (dut.pc !== 32'(4 * c) || memwrite !== e_mw[c] || dataadr !== e_adr[c] || writedata !== e_wd[c]) begin
                n_fail++;
                $display("FAIL alu_slt c%0d got pc=%h mw=%b adr=%h wd=%h want pc=%h mw=%b adr=%h wd=%h",
                         c, dut.pc, memwrite, dataadr, writedata, 32'(4 * c), e_mw[c], e_adr[c], e_wd[c]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] e_pc  [8] = '{0, 4, 8, 16, 20, 24, 24, 24};
        bit          e_mw  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        bit          e_ck  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic [31:0] e_adr [8] = '{5, 5, 0, 5, 12, 0, 0, 0};
        logic [31:0] e_wd  [8] = '{0, 0, 5, 0, 5, 0, 0, 0};
        prog[0] = 32'h20010005; prog[1] = 32'h20020005; prog[2] = 32'h10220001;
        prog[3] = 32'hAC010008; prog[4] = 32'h10200001; prog[5] = 32'hAC02000C;
        prog[6] = 32'h08000006;
        start(7);
        for (int c = 0; c < 8; c++) begin
            n_tests++;
            if (dut.pc !== e_pc[c] || memwrite !== e_mw[c]) begin
                n_fail++;
                $display("FAIL branch_jump_pc c%0d got pc=%h mw=%b want pc=%h mw=%b", c, dut.pc, memwrite, e_pc[c], e_mw[c]);
            end
            if (e_ck[c]) begin
                n_tests++;
                if (dataadr !== e_adr[c] || writedata !== e_wd[c]) begin
                    n_fail++;
                    $display("FAIL branch_jump_bus c%0d got adr=%h wd=%h want adr=%h wd=%h", c, dataadr, writedata, e_adr[c], e_wd[c]);
                end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_nop_wrap();
        logic [31:0] e_pc  [8] = '{0, 4, 8, 12, 16, 20, 24, 28};
        bit          e_mw  [8] = '{1, 0, 0, 0, 1, 1, 0, 1};
        bit          e_ck  [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        logic [31:0] e_adr [8] = '{16, 9, 0, 0, 0, 32'h104, 4, 8};
        logic [31:0] e_wd  [8] = '{0, 0, 0, 0, 9, 9, 0, 9};
        prog[0] = 32'hAC020010; prog[1] = 32'h20010009; prog[2] = 32'hFC000000;
        prog[3] = 32'h00210826; prog[4] = 32'hAC010000; prog[5] = 32'hAC010104;
        prog[6] = 32'h8C020004; prog[7] = 32'hAC020008;
        reset = 1'b0;
        load(8);
        @(negedge clk); #1;
        n_tests++;
        if (memwrite !== 1'b0 || dataadr !== 32'd16) begin
            n_fail++;
            $display("FAIL nop_sw_in_reset got mw=%b adr=%h want mw=0 adr=%h", memwrite, dataadr, 32'd16);
        end
        reset = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            n_tests++;
            if (dut.pc !== e_pc[c] || memwrite !== e_mw[c]) begin
                n_fail++;
                $display("FAIL nop_wrap_pc c%0d got pc=%h mw=%b want pc=%h mw=%b", c, dut.pc, memwrite, e_pc[c], e_mw[c]);
            end
            if (e_ck[c]) begin
                n_tests++;
                if (dataadr !== e_adr[c] || writedata !== e_wd[c]) begin
                    n_fail++;
                    $display("FAIL nop_wrap_bus c%0d got adr=%h wd=%h want adr=%h wd=%h", c, dataadr, writedata, e_adr[c], e_wd[c]);
                end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_zero_reg();
        prog[0] = 32'h20000007; prog[1] = 32'hAC000004;
        start(2);
        n_tests++;
        if (dataadr !== 32'd7 || memwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_addi got adr=%h mw=%b want adr=%h mw=0", dataadr, memwrite, 32'd7);
        end
        @(negedge clk); #1;
        n_tests++;
        if (memwrite !== 1'b1 || dataadr !== 32'd4 || writedata !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_reg_sw got mw=%b adr=%h wd=%h want mw=1 adr=%h wd=%h", memwrite, dataadr, writedata, 32'd4, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_store_prog();
        test_reset_mid();
        test_alu_slt();
        test_branch_jump();
        test_nop_wrap();
        test_zero_reg();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
